// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Multiplies by radix-2 shift-add and divides by restoring division, one bit
// per cycle on operand magnitudes, then applies the sign fixup on the way out.
// Divide-by-zero and signed overflow skip the iteration and finish in one cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start_i,
    input  logic [2:0]       MulDiv_Op_i,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    input  logic             Flush_i,
    output logic             Busy_o,
    output logic             Done_o,
    output logic [WIDTH-1:0] Result_o
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [2:0]           op_r;
    // Multiply: full product accumulator with the multiplier shifting out of the
    // low half. Divide: {partial remainder, dividend/quotient shift register}.
    logic [2*WIDTH-1:0]   acc_r;
    // Multiplicand magnitude for multiplies, divisor magnitude for divides.
    logic [WIDTH-1:0]     opnd_r;
    logic                 neg_r;
    logic                 fast_r;
    logic [WIDTH-1:0]     fast_res_r;

    logic                 accept_s;
    logic                 a_signed_s;
    logic                 b_signed_s;
    logic                 sa_s;
    logic                 sb_s;
    logic [WIDTH-1:0]     a_mag_s;
    logic [WIDTH-1:0]     b_mag_s;
    logic                 neg_in_s;
    logic                 fast_s;
    logic [WIDTH-1:0]     fast_res_s;

    logic [WIDTH:0]       mul_sum_s;
    logic [2*WIDTH-1:0]   mul_next_s;
    logic [WIDTH:0]       div_shift_s;
    logic                 div_ge_s;
    logic [WIDTH-1:0]     div_diff_s;
    logic [2*WIDTH-1:0]   div_next_s;
    logic [2*WIDTH-1:0]   iter_next_s;

    logic [2*WIDTH-1:0]   prod_fix_s;
    logic [WIDTH-1:0]     quo_fix_s;
    logic [WIDTH-1:0]     rem_fix_s;
    logic [WIDTH-1:0]     final_s;

    logic                 busy_next_s;
    logic                 done_next_s;
    logic [WIDTH-1:0]     result_next_s;

    assign accept_s = Start_i & ~Flush_i;

    // Decode operand signedness, magnitudes, result sign and the one-cycle special cases.
    always_comb begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
        case (MulDiv_Op_i)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b1;
            end
            OP_MULHSU: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b0;
            end
            default: begin
                a_signed_s = 1'b0;
                b_signed_s = 1'b0;
            end
        endcase

        sa_s    = a_signed_s & A_i[WIDTH-1];
        sb_s    = b_signed_s & B_i[WIDTH-1];
        a_mag_s = sa_s ? (ZERO_W - A_i) : A_i;
        b_mag_s = sb_s ? (ZERO_W - B_i) : B_i;

        // Remainder takes the dividend sign; product and quotient take sA^sB.
        if (MulDiv_Op_i[2] && MulDiv_Op_i[1]) begin
            neg_in_s = sa_s;
        end else begin
            neg_in_s = sa_s ^ sb_s;
        end

        fast_s     = 1'b0;
        fast_res_s = ZERO_W;
        if (MulDiv_Op_i[2] && (B_i == ZERO_W)) begin
            fast_s     = 1'b1;
            fast_res_s = MulDiv_Op_i[1] ? A_i : ALL_ONES;
        end else if (MulDiv_Op_i[2] && !MulDiv_Op_i[0] &&
                     (A_i == MIN_NEG) && (B_i == ALL_ONES)) begin
            fast_s     = 1'b1;
            fast_res_s = MulDiv_Op_i[1] ? ZERO_W : MIN_NEG;
        end else begin
            fast_s     = 1'b0;
            fast_res_s = ZERO_W;
        end
    end

    // One shift-add or one restoring-divide step on the accumulator.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                      (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
        mul_next_s  = {mul_sum_s, acc_r[WIDTH-1:1]};

        div_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
        div_ge_s    = (div_shift_s >= {1'b0, opnd_r});
        // When the subtract succeeds the difference is below the divisor, so W bits suffice.
        div_diff_s  = div_shift_s[WIDTH-1:0] - opnd_r;
        if (div_ge_s) begin
            div_next_s = {div_diff_s, acc_r[WIDTH-2:0], 1'b1};
        end else begin
            div_next_s = {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
        end

        iter_next_s = op_r[2] ? div_next_s : mul_next_s;
    end

    // Sign fixup and selection of the word that goes to writeback.
    always_comb begin
        prod_fix_s = neg_r ? ({(2*WIDTH){1'b0}} - acc_r) : acc_r;
        quo_fix_s  = neg_r ? (ZERO_W - acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
        rem_fix_s  = neg_r ? (ZERO_W - acc_r[2*WIDTH-1:WIDTH]) : acc_r[2*WIDTH-1:WIDTH];
        final_s    = ZERO_W;
        if (fast_r) begin
            final_s = fast_res_r;
        end else begin
            case (op_r)
                OP_MUL:                       final_s = prod_fix_s[WIDTH-1:0];
                OP_MULH, OP_MULHSU, OP_MULHU: final_s = prod_fix_s[2*WIDTH-1:WIDTH];
                OP_DIV, OP_DIVU:              final_s = quo_fix_s;
                OP_REM, OP_REMU:              final_s = rem_fix_s;
                default:                      final_s = ZERO_W;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; flush always returns to IDLE.
    always_comb begin
        state_next_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = fast_s ? ST_DONE : ST_CALC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (Flush_i) begin
                    state_next_s = ST_IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_CALC;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; Busy_o also covers the Done_o cycle.
    always_comb begin
        busy_next_s   = 1'b0;
        done_next_s   = 1'b0;
        result_next_s = Result_o;
        case (state_r)
            ST_IDLE: begin
                busy_next_s = accept_s;
            end
            ST_CALC: begin
                busy_next_s = ~Flush_i;
            end
            ST_DONE: begin
                if (Flush_i) begin
                    busy_next_s   = 1'b0;
                    done_next_s   = 1'b0;
                    result_next_s = Result_o;
                end else begin
                    busy_next_s   = 1'b1;
                    done_next_s   = 1'b1;
                    result_next_s = final_s;
                end
            end
            default: begin
                busy_next_s   = 1'b0;
                done_next_s   = 1'b0;
                result_next_s = Result_o;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            Busy_o   <= 1'b0;
            Done_o   <= 1'b0;
            Result_o <= ZERO_W;
        end else begin
            Busy_o   <= busy_next_s;
            Done_o   <= done_next_s;
            Result_o <= result_next_s;
        end
    end

    // Datapath: capture operands on acceptance, iterate in CALC.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_r      <= {CNT_W{1'b0}};
            op_r       <= 3'b000;
            acc_r      <= {(2*WIDTH){1'b0}};
            opnd_r     <= ZERO_W;
            neg_r      <= 1'b0;
            fast_r     <= 1'b0;
            fast_res_r <= ZERO_W;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        cnt_r      <= {CNT_W{1'b0}};
                        op_r       <= MulDiv_Op_i;
                        neg_r      <= neg_in_s;
                        fast_r     <= fast_s;
                        fast_res_r <= fast_res_s;
                        if (MulDiv_Op_i[2]) begin
                            acc_r  <= {ZERO_W, a_mag_s};
                            opnd_r <= b_mag_s;
                        end else begin
                            acc_r  <= {ZERO_W, b_mag_s};
                            opnd_r <= a_mag_s;
                        end
                    end
                end
                ST_CALC: begin
                    cnt_r <= cnt_r + CNT_ONE;
                    acc_r <= iter_next_s;
                end
                ST_DONE: begin
                    cnt_r <= cnt_r;
                end
                default: begin
                    cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

endmodule
